// File: rtl/chip8_fetch.sv
// chip8_fetch: reads PC and PC+1 and hands the big-endian opcode to the CPU (CHIP8_FETCH_PREFETCH_EN adds a prefetch buffer).
// Latency: instr_valid 2*READ_LATENCY+2 cycles after fetch_req; one cycle on a prefetch hit.
// Backpressure: fetch_req is dropped while busy is high; memory reads are never stalled.
module chip8_fetch #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 12
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD_HI, WAIT_HI, RD_LO, WAIT_LO, DONE} state_t;
  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi_byte;
  logic [1:0]        lat_cnt;
  logic              data_rdy;
  logic              accept;
  logic              pf_hit;
  logic              pf_run;
  logic              start_pf;
  logic [15:0]       pf_dat;

  assign data_rdy = (lat_cnt == LAT);

  always_comb begin
    state_nxt   = state;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;
    busy        = 1'b1;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        accept = fetch_req;
        if (fetch_req) state_nxt = pf_hit ? DONE : RD_HI;
      end
      RD_HI: begin
        mem_rd    = 1'b1;
        mem_addr  = addr;
        state_nxt = WAIT_HI;
      end
      // The low-byte read goes out in the same cycle the high byte lands.
      WAIT_HI: begin
        if (data_rdy) begin
          mem_rd    = 1'b1;
          mem_addr  = addr + ADDR_W'(1);
          state_nxt = WAIT_LO;
        end
      end
      RD_LO: begin
        mem_rd    = 1'b1;
        mem_addr  = addr + ADDR_W'(1);
        state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (data_rdy) state_nxt = pf_run ? IDLE : DONE;
      end
      DONE: begin
        busy        = 1'b0;
        instr_valid = 1'b1;
        accept      = fetch_req;
        if (fetch_req)     state_nxt = pf_hit ? DONE : RD_HI;
        else if (start_pf) state_nxt = RD_HI;
        else               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      hi_byte     <= 8'h00;
      lat_cnt     <= 2'd0;
      instruction <= 16'h0000;
    end else begin
      state   <= state_nxt;
      lat_cnt <= (state_nxt != state) ? 2'd1 : lat_cnt + 2'd1;
      if (accept)        addr <= pc_in;
      else if (start_pf) addr <= addr + ADDR_W'(2);
      if (state == WAIT_HI && data_rdy) hi_byte <= mem_rdata;
      if (state == WAIT_LO && data_rdy && !pf_run) instruction <= {hi_byte, mem_rdata};
      if (accept && pf_hit) instruction <= pf_dat;
    end
  end

`ifdef CHIP8_FETCH_PREFETCH_EN
  logic              pf_vld;
  logic              pf_drop;
  logic [ADDR_W-1:0] pf_tag;

  assign pf_hit   = pf_vld && (pc_in == pf_tag) && !flush;
  assign start_pf = (state == DONE) && !fetch_req;

  // A flush while a prefetch is in flight lets the reads finish but drops the result.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      pf_vld  <= 1'b0;
      pf_drop <= 1'b0;
      pf_run  <= 1'b0;
      pf_tag  <= '0;
      pf_dat  <= 16'h0000;
    end else begin
      if (flush || accept) pf_vld <= 1'b0;
      if (flush && pf_run) pf_drop <= 1'b1;
      if (start_pf) begin
        pf_run  <= 1'b1;
        pf_drop <= 1'b0;
      end
      if (pf_run && state == WAIT_LO && data_rdy) begin
        pf_run <= 1'b0;
        if (!pf_drop && !flush) begin
          pf_vld <= 1'b1;
          pf_tag <= addr;
          pf_dat <= {hi_byte, mem_rdata};
        end
      end
    end
  end
`else
  logic flush_unused;
  assign flush_unused = flush;
  assign pf_hit       = 1'b0;
  assign pf_run       = 1'b0;
  assign start_pf     = 1'b0;
  assign pf_dat       = 16'h0000;
`endif

endmodule

// File: tb/tb_chip8_fetch.sv
// Bench for chip8_fetch: two instances (READ_LATENCY 1 and 3) share one stimulus stream and a byte memory.
module tb_chip8_fetch;

`ifdef CHIP8_FETCH_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic             clk, reset, fetch_req, flush;
  logic [11:0]      pc_in;
  logic [1:0]       d_rd, d_vld, d_busy;
  logic [1:0][11:0] d_addr;
  logic [1:0][7:0]  d_rdata;
  logic [1:0][15:0] d_instr;
  logic [7:0]       mem [4096];

  int checks = 0, failures = 0, cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = (g == 0) ? 1 : 3;
    logic [2:0]       pv;
    logic [2:0][11:0] pa;

    chip8_fetch #(.READ_LATENCY(L), .ADDR_W(12)) dut (
      .cpu_clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_in(pc_in), .flush(flush),
      .mem_addr(d_addr[g]), .mem_rd(d_rd[g]), .mem_rdata(d_rdata[g]),
      .instruction(d_instr[g]), .instr_valid(d_vld[g]), .busy(d_busy[g])
    );

    // Memory returns data exactly L cycles after the read strobe, junk otherwise.
    always @(posedge clk) begin
      pv <= {pv[1:0], d_rd[g]};
      pa <= {pa[1:0], d_addr[g]};
    end
    assign d_rdata[g] = pv[L-1] ? mem[pa[L-1]] : 8'hEE;
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h (cycle %0d)", name, idx, act, exp, cyc);
    end
  endtask

  // Model: a fetch accepted in cycle t reads in t+1 and t+1+L, is busy t+1..t+1+2L,
  // and pulses valid in t+2+2L. Prefetch jobs run on the same timeline without the pulse.
  bit          armed = 1'b0;
  bit          m_job [2], m_pf [2], pf_v [2], pf_drop [2];
  int          m_s [2], m_done [2];
  logic [11:0] m_a [2], m_last [2], pf_tag [2];
  logic [15:0] m_instr [2], m_pend [2], pf_dat [2];

  int          vn [2], vcyc [2], rdn [2];
  logic [15:0] vins [2];
  logic [11:0] rdlog [2][256];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int          L;
      logic        e_rd, e_busy, e_vld;
      logic [11:0] e_addr, a1;
      L  = (i == 0) ? 1 : 3;
      a1 = m_a[i] + 12'd1;
      if (cyc == m_done[i]) m_instr[i] = m_pend[i];
      e_busy = m_job[i] && cyc >= m_s[i] && cyc <= m_s[i] + 2 * L;
      e_rd   = m_job[i] && (cyc == m_s[i] || cyc == m_s[i] + L);
      e_addr = !e_rd ? 12'h000 : (cyc == m_s[i]) ? m_a[i] : a1;
      e_vld  = (cyc == m_done[i]);
      if (armed) begin
        chk("busy",        i, 32'(d_busy[i]),  32'(e_busy));
        chk("mem_rd",      i, 32'(d_rd[i]),    32'(e_rd));
        chk("mem_addr",    i, 32'(d_addr[i]),  32'(e_addr));
        chk("instr_valid", i, 32'(d_vld[i]),   32'(e_vld));
        chk("instruction", i, 32'(d_instr[i]), 32'(m_instr[i]));
      end
      if (d_vld[i]) begin
        vn[i]++;
        vcyc[i] = cyc;
        vins[i] = d_instr[i];
      end
      if (d_rd[i]) begin
        rdlog[i][rdn[i] % 256] = d_addr[i];
        rdn[i]++;
      end
      if (reset) begin
        m_job[i] = 1'b0; m_done[i] = -100; m_instr[i] = 16'h0000;
        pf_v[i]  = 1'b0; pf_drop[i] = 1'b0;
      end else if (armed) begin
        if (m_job[i] && cyc == m_s[i] + 2 * L) begin
          m_job[i] = 1'b0;
          if (!m_pf[i]) begin
            m_done[i] = cyc + 1;
            m_pend[i] = {mem[m_a[i]], mem[a1]};
            m_last[i] = m_a[i];
          end else if (!pf_drop[i] && !flush) begin
            pf_v[i]   = 1'b1;
            pf_tag[i] = m_a[i];
            pf_dat[i] = {mem[m_a[i]], mem[a1]};
          end
        end
        if (flush) begin
          pf_v[i] = 1'b0;
          if (m_job[i] && m_pf[i]) pf_drop[i] = 1'b1;
        end
        if (!e_busy && fetch_req) begin
          if (PF && pf_v[i] && pc_in == pf_tag[i] && !flush) begin
            m_done[i] = cyc + 1;
            m_pend[i] = pf_dat[i];
            m_last[i] = pc_in;
          end else begin
            m_job[i] = 1'b1; m_pf[i] = 1'b0; m_s[i] = cyc + 1; m_a[i] = pc_in;
          end
          pf_v[i] = 1'b0;
        end else if (PF && cyc == m_done[i]) begin
          m_job[i] = 1'b1; m_pf[i] = 1'b1; m_s[i] = cyc + 1; m_a[i] = m_last[i] + 12'd2;
          pf_drop[i] = 1'b0;
        end
      end
    end
    if (reset) armed = 1'b1;
    cyc++;
  end

  int rq;
  int n0 [2], v0 [2];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [11:0] pc, output int rc);
    fetch_req = 1'b1;
    pc_in     = pc;
    rc        = cyc;
    step(1);
    fetch_req = 1'b0;
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      n0[i] = rdn[i];
      v0[i] = vn[i];
    end
  endtask

  initial begin
    reset = 1'b1; fetch_req = 1'b0; flush = 1'b0; pc_in = 12'h000;
    for (int a = 0; a < 4096; a++) mem[a] = 8'(a * 7 + 3);
    mem[12'h200] = 8'h61; mem[12'h201] = 8'h22;
    mem[12'hFFF] = 8'h80; mem[12'h000] = 8'h14;
    mem[12'h2A1] = 8'hA2; mem[12'h2A2] = 8'hB3;
    mem[12'h300] = 8'h12; mem[12'h301] = 8'h34;
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_instruction", 0, 32'(d_instr[0]), 32'h0000);
    chk("rst_busy",        0, 32'(d_busy[0]),  32'h0);
    chk("rst_mem_rd",      1, 32'(d_rd[1]),    32'h0);

    // Basic fetch at 200.
    snap();
    request(12'h200, rq);
    step(20);
    for (int i = 0; i < 2; i++) begin
      chk("t1_latency", i, vcyc[i] - rq, (i == 0) ? 4 : 8);
      chk("t1_opcode",  i, 32'(vins[i]), 32'h6122);
      chk("t1_addr_hi", i, 32'(rdlog[i][n0[i] % 256]), 32'h200);
      chk("t1_addr_lo", i, 32'(rdlog[i][(n0[i] + 1) % 256]), 32'h201);
    end

    // Wrap from FFF to 000.
    snap();
    request(12'hFFF, rq);
    step(20);
    for (int i = 0; i < 2; i++) begin
      chk("t2_opcode",  i, 32'(vins[i]), 32'h8014);
      chk("t2_addr_hi", i, 32'(rdlog[i][n0[i] % 256]), 32'hFFF);
      chk("t2_addr_lo", i, 32'(rdlog[i][(n0[i] + 1) % 256]), 32'h000);
      chk("t2_latency", i, vcyc[i] - rq, (i == 0) ? 4 : 8);
    end

    // Requests while busy are dropped; odd address.
    snap();
    rq = cyc;
    for (int k = 0; k < 4; k++) begin
      fetch_req = 1'b1;
      pc_in     = (k == 0) ? 12'h2A1 : 12'(12'h123 * k);
      step(1);
    end
    fetch_req = 1'b0;
    step(20);
    for (int i = 0; i < 2; i++) begin
      chk("t3_pulses", i, vn[i] - v0[i], 1);
      chk("t3_reads",  i, rdn[i] - n0[i], PF ? 4 : 2);
      chk("t3_opcode", i, 32'(vins[i]), 32'hA2B3);
    end

    // Request held high into the done cycle is accepted back to back at latency 1.
    snap();
    fetch_req = 1'b1;
    pc_in     = 12'h2A1;
    step(5);
    fetch_req = 1'b0;
    step(25);
    chk("t3b_pulses", 0, vn[0] - v0[0], 2);
    chk("t3b_pulses", 1, vn[1] - v0[1], 1);

    // Reset while the L=1 instance waits for the low byte.
    snap();
    request(12'h300, rq);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t4_valid",       0, 32'(d_vld[0]),   32'h0);
    chk("t4_busy",        0, 32'(d_busy[0]),  32'h0);
    chk("t4_mem_rd",      0, 32'(d_rd[0]),    32'h0);
    chk("t4_mem_addr",    0, 32'(d_addr[0]),  32'h000);
    chk("t4_instruction", 0, 32'(d_instr[0]), 32'h0000);
    step(12);
    for (int i = 0; i < 2; i++) chk("t4_no_pulse", i, vn[i] - v0[i], 0);

    // Prefetch hit, then flush forcing a full fetch.
    mem[12'h200] = 8'h60; mem[12'h201] = 8'h20;
    mem[12'h202] = 8'h80; mem[12'h203] = 8'h15;
    mem[12'h204] = 8'hA3; mem[12'h205] = 8'h4C;
    request(12'h200, rq);
    step(20);
    for (int i = 0; i < 2; i++) chk("t6_first_opcode", i, 32'(vins[i]), 32'h6020);
    snap();
    request(12'h202, rq);
    #6;
    for (int i = 0; i < 2; i++) chk("t6_hit_reads", i, rdn[i] - n0[i], PF ? 0 : 1);
    step(20);
    for (int i = 0; i < 2; i++) begin
      chk("t6_hit_latency", i, vcyc[i] - rq, PF ? 1 : ((i == 0) ? 4 : 8));
      chk("t6_hit_opcode",  i, 32'(vins[i]), 32'h8015);
    end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    snap();
    request(12'h204, rq);
    step(20);
    for (int i = 0; i < 2; i++) begin
      chk("t6_flush_latency", i, vcyc[i] - rq, (i == 0) ? 4 : 8);
      chk("t6_flush_opcode",  i, 32'(vins[i]), 32'hA34C);
      chk("t6_flush_addr",    i, 32'(rdlog[i][n0[i] % 256]), 32'h204);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
